// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared LFSR definitions for the PRBS generator/checker pair
// Provides the checker state type, LFSR width/reset constants and the
// single-step LFSR recurrence used by both the generator and the checker.
package prbs_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   localparam int              LFSR_W     = 32;
   localparam logic [LFSR_W-1:0] LFSR_RESET = '1;

   // One step of the mask stream: shift left, feed back bit31 ^ bit30.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], cur[LFSR_W-1] ^ cur[LFSR_W-2]};
   endfunction

endpackage

// File: rtl/popcount32.sv
// rtl/popcount32.sv - combinational population count of a 32-bit word
// Only compiled when PRBS_BIT_ERR_CNT_EN is defined (its sole user is the
// bit error counter of prbs_checker_00).
// Ports:
//   data  in  32  word to count
//   cnt   out 6   number of set bits in data (0..32)
`ifdef PRBS_BIT_ERR_CNT_EN
module popcount32 (
   input  logic [31:0] data,
   output logic [5:0]  cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + 6'(data[i]);
      end
   end

endmodule
`endif

// File: rtl/prbs_checker_00.sv
// rtl/prbs_checker_00.sv - self-synchronising checker for the 32-bit LFSR mask stream
// Seeds from the first nonzero word, confirms LOCK_MATCHES predicted words,
// then flywheels the local LFSR and counts word/bit errors while locked.
// Optional feature: PRBS_BIT_ERR_CNT_EN enables the bit error counter
// (otherwise bit_err_cnt is tied to 0).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   data_valid    data_in valid this cycle
//   data_in       received LFSR word
//   clr_cnt       synchronous clear of the statistics counters
//   locked        checker locked to the sequence
//   err_pulse     1-cycle pulse on a mismatch while locked
//   lock_lost     1-cycle pulse when lock drops
//   word_cnt      words checked while locked (saturating)
//   word_err_cnt  mismatched words while locked (saturating)
//   bit_err_cnt   mismatched bits while locked (saturating)
module prbs_checker_00
   import prbs_pkg::*;
#(
   parameter int LOCK_MATCHES = 4,
   parameter int LOSS_MISSES  = 3,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_valid,
   input  logic [LFSR_W-1:0] data_in,
   input  logic              clr_cnt,
   output logic              locked,
   output logic              err_pulse,
   output logic              lock_lost,
   output logic [CNT_W-1:0]  word_cnt,
   output logic [CNT_W-1:0]  word_err_cnt,
   output logic [CNT_W-1:0]  bit_err_cnt
);

   localparam int MW = $clog2(LOCK_MATCHES + 1);
   localparam int LW = $clog2(LOSS_MISSES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   chk_state_t        state, state_n;
   logic [LFSR_W-1:0] expected, exp_n;
   logic [MW-1:0]     match_cnt, match_n;
   logic [LW-1:0]     miss_cnt, miss_n;
   logic              hit;
   logic              err_d, lost_d, word_inc;

   assign hit = (data_in == expected);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         expected  <= LFSR_RESET;
         match_cnt <= '0;
         miss_cnt  <= '0;
      end else begin
         state     <= state_n;
         expected  <= exp_n;
         match_cnt <= match_n;
         miss_cnt  <= miss_n;
      end
   end

   // next-state logic; nothing moves on idle cycles
   always_comb begin
      state_n = state;
      exp_n   = expected;
      match_n = match_cnt;
      miss_n  = miss_cnt;
      if (data_valid) begin
         case (state)
            HUNT: begin
               // the all-zero word is the LFSR lockup state and can never seed
               if (data_in != '0) begin
                  exp_n   = lfsr_next(data_in);
                  match_n = '0;
                  state_n = VERIFY;
               end
            end
            VERIFY: begin
               if (hit) begin
                  exp_n = lfsr_next(expected);
                  if (match_cnt == MW'(LOCK_MATCHES - 1)) begin
                     state_n = LOCKED;
                     match_n = '0;
                     miss_n  = '0;
                  end else begin
                     match_n = match_cnt + 1'b1;
                  end
               end else if (data_in != '0) begin
                  exp_n   = lfsr_next(data_in);
                  match_n = '0;
               end else begin
                  match_n = '0;
                  state_n = HUNT;
               end
            end
            LOCKED: begin
               // flywheel: keep predicting even across errors
               exp_n = lfsr_next(expected);
               if (hit) begin
                  miss_n = '0;
               end else if (miss_cnt == LW'(LOSS_MISSES - 1)) begin
                  miss_n  = '0;
                  state_n = HUNT;
               end else begin
                  miss_n = miss_cnt + 1'b1;
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   // output decode (registered below)
   always_comb begin
      word_inc = data_valid && (state == LOCKED);
      err_d    = word_inc && !hit;
      lost_d   = err_d && (miss_cnt == LW'(LOSS_MISSES - 1));
   end

   assign locked = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_pulse <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         err_pulse <= err_d;
         lock_lost <= lost_d;
      end
   end

   // clr_cnt wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         word_cnt     <= '0;
         word_err_cnt <= '0;
      end else begin
         if (word_inc && word_cnt != CNT_MAX)
            word_cnt <= word_cnt + 1'b1;
         if (err_d && word_err_cnt != CNT_MAX)
            word_err_cnt <= word_err_cnt + 1'b1;
      end
   end

`ifdef PRBS_BIT_ERR_CNT_EN
   // sum is wide enough for both the counter and a full 32-bit popcount
   localparam int SW = ((CNT_W > 6) ? CNT_W : 6) + 1;
   logic [5:0]    pop;
   logic [SW-1:0] bit_sum;

   popcount32 u_popcount (
      .data (data_in ^ expected),
      .cnt  (pop)
   );

   assign bit_sum = SW'(bit_err_cnt) + SW'(pop);

   always_ff @(posedge clk) begin
      if (rst || clr_cnt)
         bit_err_cnt <= '0;
      else if (err_d)
         bit_err_cnt <= (bit_sum > SW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
   end
`else
   assign bit_err_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs_checker_00.sv
// tb/tb_prbs_checker_00.sv - self-checking bench for prbs_checker_00
module tb_prbs_checker_00;

   localparam int LM = 4;
   localparam int LS = 3;
`ifdef PRBS_BIT_ERR_CNT_EN
   localparam int BE = 1;
`else
   localparam int BE = 0;
`endif

   logic        clk = 1'b0;
   logic        rst, data_valid, clr_cnt;
   logic [31:0] data_in;
   logic        locked, err_pulse, lock_lost;
   logic [31:0] word_cnt, word_err_cnt, bit_err_cnt;
   logic        locked_s, err_pulse_s, lock_lost_s;
   logic [2:0]  word_cnt_s, word_err_cnt_s, bit_err_cnt_s;

   always #5 clk = ~clk;

   prbs_checker_00 #(.LOCK_MATCHES(LM), .LOSS_MISSES(LS), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in), .clr_cnt(clr_cnt),
      .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
      .word_cnt(word_cnt), .word_err_cnt(word_err_cnt), .bit_err_cnt(bit_err_cnt));

   // narrow-counter copy so saturation is reachable in a short run
   prbs_checker_00 #(.LOCK_MATCHES(LM), .LOSS_MISSES(LS), .CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in), .clr_cnt(clr_cnt),
      .locked(locked_s), .err_pulse(err_pulse_s), .lock_lost(lock_lost_s),
      .word_cnt(word_cnt_s), .word_err_cnt(word_err_cnt_s), .bit_err_cnt(bit_err_cnt_s));

   int tests = 0;
   int fails = 0;

   // reference model: mode 0=hunting, 1=confirming, 2=locked
   int          m_mode, m_run, m_miss;
   logic [31:0] m_exp;
   logic        m_err, m_lost;
   longint      m_wc, m_ec, m_bc, m_wc3, m_ec3, m_bc3;

   function automatic logic [31:0] nx(input logic [31:0] x);
      return 32'((x << 1) | (((x >> 31) ^ (x >> 30)) & 32'd1));
   endfunction

   function automatic longint sat(input longint v, input longint mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_run = 0; m_miss = 0; m_exp = 32'hFFFF_FFFF;
      m_err = 0; m_lost = 0;
      m_wc = 0; m_ec = 0; m_bc = 0; m_wc3 = 0; m_ec3 = 0; m_bc3 = 0;
   endtask

   task automatic model_update(input logic v, input logic [31:0] d, input logic c, input logic r);
      int inc_w, inc_e, bits;
      if (r) begin
         model_reset();
         return;
      end
      m_err = 0; m_lost = 0; inc_w = 0; inc_e = 0; bits = 0;
      if (v) begin
         if (m_mode == 0) begin
            if (d != 0) begin m_exp = nx(d); m_run = 0; m_mode = 1; end
         end else if (m_mode == 1) begin
            if (d == m_exp) begin
               m_exp = nx(m_exp); m_run++;
               if (m_run == LM) begin m_mode = 2; m_miss = 0; end
            end else if (d != 0) begin
               m_exp = nx(d); m_run = 0;
            end else begin
               m_mode = 0;
            end
         end else begin
            inc_w = 1;
            if (d == m_exp) m_miss = 0;
            else begin
               m_err = 1; inc_e = 1; m_miss++;
               bits = BE * $countones(d ^ m_exp);
               if (m_miss == LS) begin m_mode = 0; m_lost = 1; m_miss = 0; end
            end
            m_exp = nx(m_exp);
         end
      end
      if (c) begin
         m_wc = 0; m_ec = 0; m_bc = 0; m_wc3 = 0; m_ec3 = 0; m_bc3 = 0;
      end else begin
         m_wc  = sat(m_wc + inc_w, 64'hFFFF_FFFF);
         m_ec  = sat(m_ec + inc_e, 64'hFFFF_FFFF);
         m_bc  = sat(m_bc + bits, 64'hFFFF_FFFF);
         m_wc3 = sat(m_wc3 + inc_w, 7);
         m_ec3 = sat(m_ec3 + inc_e, 7);
         m_bc3 = sat(m_bc3 + bits, 7);
      end
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      chk("locked", locked, m_mode == 2);
      chk("err_pulse", err_pulse, m_err);
      chk("lock_lost", lock_lost, m_lost);
      chk("word_cnt", word_cnt, m_wc);
      chk("word_err_cnt", word_err_cnt, m_ec);
      chk("bit_err_cnt", bit_err_cnt, m_bc);
      chk("locked_s", locked_s, m_mode == 2);
      chk("word_cnt_s", word_cnt_s, m_wc3);
      chk("word_err_cnt_s", word_err_cnt_s, m_ec3);
      chk("bit_err_cnt_s", bit_err_cnt_s, m_bc3);
   endtask

   // drive at negedge, model at posedge, compare at the following negedge
   task automatic step(input logic v, input logic [31:0] d, input logic c, input logic r);
      rst = r; data_valid = v; data_in = d; clr_cnt = c;
      @(posedge clk);
      model_update(v, d, c, r);
      @(negedge clk);
      check_model();
   endtask

   logic [31:0] h;  // local generator for hand-written sequences
   task automatic good();
      step(1'b1, h, 1'b0, 1'b0); h = nx(h);
   endtask
   task automatic bad(input logic [31:0] mask, input logic c);
      step(1'b1, h ^ mask, c, 1'b0); h = nx(h);
   endtask

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        lk, er, ll;
      int          wc, ec, bc;
   } vec_t;
   vec_t tbl[9];

   initial begin
      rst = 1'b1; data_valid = 1'b0; data_in = '0; clr_cnt = 1'b0;
      model_reset();
      step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("reset_locked", locked, 0);
      chk("reset_word_cnt", word_cnt, 0);

      // acquisition, one clean locked word, one bit-0 error, recovery
      tbl[0] = '{1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0};
      tbl[2] = '{1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0};
      tbl[3] = '{1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0};
      tbl[4] = '{1, 32'hFFFF_FFF0, 1, 0, 0, 0, 0, 0};
      tbl[5] = '{1, 32'hFFFF_FFE0, 1, 0, 0, 1, 0, 0};
      tbl[6] = '{1, 32'hFFFF_FFC1, 1, 1, 0, 2, 1, BE};
      tbl[7] = '{1, 32'hFFFF_FF80, 1, 0, 0, 3, 1, BE};
      tbl[8] = '{0, 32'h1234_5678, 1, 0, 0, 3, 1, BE};
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].v, tbl[i].d, 1'b0, 1'b0);
         chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
         chk($sformatf("tbl%0d_err", i), err_pulse, tbl[i].er);
         chk($sformatf("tbl%0d_lost", i), lock_lost, tbl[i].ll);
         chk($sformatf("tbl%0d_wc", i), word_cnt, tbl[i].wc);
         chk($sformatf("tbl%0d_ec", i), word_err_cnt, tbl[i].ec);
         chk($sformatf("tbl%0d_bc", i), bit_err_cnt, tbl[i].bc);
      end
      h = 32'hFFFF_FF00;

      // three consecutive errors drop lock; clean stream relocks after 5 words
      step(1'b0, 32'h0, 1'b1, 1'b0);
      bad(32'h1, 1'b0); bad(32'h1, 1'b0);
      chk("miss2_locked", locked, 1);
      bad(32'h1, 1'b0);
      chk("miss3_lost", lock_lost, 1);
      chk("miss3_locked", locked, 0);
      chk("miss3_ec", word_err_cnt, 3);
      for (int i = 0; i < 4; i++) good();
      chk("relock4_locked", locked, 0);
      good();
      chk("relock5_locked", locked, 1);

      // zeros never seed; idle gaps while confirming do not disturb prediction
      step(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 1'b0, 1'b0);
      chk("zero_locked", locked, 0);
      h = 32'h8000_0001;
      good(); step(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      good(); good(); step(1'b0, 32'h0, 1'b0, 1'b0); step(1'b0, 32'h1, 1'b0, 1'b0);
      good();
      chk("gap_prelock", locked, 0);
      good();
      chk("gap_locked", locked, 1);

      // clear beats a same-cycle error; then saturate the narrow counters
      bad(32'h0000_0100, 1'b1);
      chk("clr_err_pulse", err_pulse, 1);
      chk("clr_ec", word_err_cnt, 0);
      for (int i = 0; i < 10; i++) good();
      chk("sat_wc_s", word_cnt_s, 7);
      chk("sat_wc", word_cnt, 10);
      bad(32'hFFFF_FFFF, 1'b0); bad(32'hFFFF_FFFF, 1'b0);
      chk("sat_bc_s", bit_err_cnt_s, BE ? 7 : 0);
      good();
      chk("sat_still_locked", locked, 1);

      // reset while locked
      step(1'b1, h, 1'b0, 1'b1);
      chk("rst_locked", locked, 0);
      chk("rst_lost", lock_lost, 0);
      chk("rst_wc", word_cnt, 0);
      chk("rst_ec", word_err_cnt, 0);

      // randomized stream: mostly valid LFSR words with corruption, zeros, reseeds, clears
      h = 32'hACE1_0001;
      for (int n = 0; n < 3000; n++) begin
         logic        v, c, r;
         logic [31:0] d;
         int          k;
         v = ($urandom_range(0, 7) != 0);
         c = ($urandom_range(0, 199) == 0);
         r = ($urandom_range(0, 999) == 0);
         k = $urandom_range(0, 99);
         d = h;
         if (k < 8) d = h ^ (32'h1 << $urandom_range(0, 31));
         else if (k < 10) d = h ^ $urandom();
         else if (k < 12) d = 32'h0;
         else if (k < 13) begin h = $urandom() | 32'h1; d = h; end
         step(v, d, c, r);
         if (v) h = nx(h);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
